// File: rtl/regfile_writeback_buffer_if.sv
// regfile_writeback_buffer_if: producer, drain and forwarding signals of the writeback buffer
// master: drives producer results, wb_hold and forwarding indices; observes everything else.
// slave: the buffer itself; drives ready, register-file write port, forwarding results and count.
interface regfile_writeback_buffer_if #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W = 5
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic mem_valid;
  logic mem_ready;
  logic [IDX_W-1:0] mem_index;
  logic [DATA_W-1:0] mem_data;
  logic alu_valid;
  logic alu_ready;
  logic [IDX_W-1:0] alu_index;
  logic [DATA_W-1:0] alu_data;
  logic wb_hold;
  logic rf_write;
  logic [IDX_W-1:0] rf_write_index;
  logic [DATA_W-1:0] rf_write_data;
  logic [IDX_W-1:0] fwd_index1;
  logic fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic [IDX_W-1:0] fwd_index2;
  logic fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [CW-1:0] count;
  modport master (
    output mem_valid, mem_index, mem_data, alu_valid, alu_index, alu_data, wb_hold, fwd_index1, fwd_index2,
    input mem_ready, alu_ready, rf_write, rf_write_index, rf_write_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );
  modport slave (
    input mem_valid, mem_index, mem_data, alu_valid, alu_index, alu_data, wb_hold, fwd_index1, fwd_index2,
    output mem_ready, alu_ready, rf_write, rf_write_index, rf_write_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );
endinterface

// File: rtl/regfile_writeback_buffer.sv
// regfile_writeback_buffer: in-order queue merging ALU and memory results onto one register-file write port
// clock_i: posedge clock; clear_n_i: async active-low reset; bus: producer handshakes, drain port,
// forwarding lookups and queue occupancy (see regfile_writeback_buffer_if).
module regfile_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W = 5
) (
  input logic clock_i,
  input logic clear_n_i,
  regfile_writeback_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, alu_ptr, p;
  logic [CW-1:0] count_q, count_d;
  logic rf_write_q;
  logic [IDX_W-1:0] rf_idx_q;
  logic [DATA_W-1:0] rf_data_q;
  logic mem_st, alu_st, pop;
  logic hit1, hit2;
  logic [DATA_W-1:0] dat1, dat2;
  // ready looks only at registered occupancy, so a full queue never accepts even when popping
  assign bus.mem_ready = clear_n_i && (count_q < CW'(DEPTH));
  assign bus.alu_ready = clear_n_i && (count_q < CW'(DEPTH - 1));
  // index 0 is a completed handshake that is simply dropped
  assign mem_st = bus.mem_valid && bus.mem_ready && (bus.mem_index != '0);
  assign alu_st = bus.alu_valid && bus.alu_ready && (bus.alu_index != '0);
  assign pop = (count_q != '0) && !bus.wb_hold;
  assign alu_ptr = wr_ptr_q + PW'(mem_st);
  assign wr_ptr_d = alu_ptr + PW'(alu_st);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign count_d = count_q + CW'(mem_st) + CW'(alu_st) - CW'(pop);
  always_ff @(posedge clock_i) begin
    if (mem_st) begin
      idx_q[wr_ptr_q] <= bus.mem_index;
      data_q[wr_ptr_q] <= bus.mem_data;
    end
    if (alu_st) begin
      idx_q[alu_ptr] <= bus.alu_index;
      data_q[alu_ptr] <= bus.alu_data;
    end
  end
  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rf_write_q <= 1'b0;
      rf_idx_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rf_write_q <= pop;
      if (pop) begin
        rf_idx_q <= idx_q[rd_ptr_q];
        rf_data_q <= data_q[rd_ptr_q];
      end
    end
  end
  // output register is the oldest pending value; queue entries scanned oldest to youngest so the last match wins
  always_comb begin
    p = '0;
    hit1 = rf_write_q && (rf_idx_q == bus.fwd_index1);
    dat1 = hit1 ? rf_data_q : '0;
    hit2 = rf_write_q && (rf_idx_q == bus.fwd_index2);
    dat2 = hit2 ? rf_data_q : '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (idx_q[p] == bus.fwd_index1)) begin
        hit1 = 1'b1;
        dat1 = data_q[p];
      end
      if ((CW'(k) < count_q) && (idx_q[p] == bus.fwd_index2)) begin
        hit2 = 1'b1;
        dat2 = data_q[p];
      end
    end
  end
  assign bus.fwd_hit1 = hit1 && (bus.fwd_index1 != '0);
  assign bus.fwd_data1 = bus.fwd_hit1 ? dat1 : '0;
  assign bus.fwd_hit2 = hit2 && (bus.fwd_index2 != '0);
  assign bus.fwd_data2 = bus.fwd_hit2 ? dat2 : '0;
  assign bus.rf_write = rf_write_q;
  assign bus.rf_write_index = rf_idx_q;
  assign bus.rf_write_data = rf_data_q;
  assign bus.count = count_q;
endmodule
